// File: rtl/vga_pkg.sv
// Shared raster-timing definitions: default 640x480@60 timing, axis phases and
// the helpers that turn a per-axis position into a phase.
package vga_pkg;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;
    localparam int DEF_CNT_W     = 10;

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FRONT,
        PH_SYNC,
        PH_BACK
    } phase_e;

    function automatic int axis_total(input int visible, input int front,
                                      input int sync, input int back);
        return visible + front + sync + back;
    endfunction

    function automatic phase_e phase_of(input int pos, input int visible,
                                        input int front, input int sync);
        if (pos < visible)
            return PH_ACTIVE;
        else if (pos < visible + front)
            return PH_FRONT;
        else if (pos < visible + front + sync)
            return PH_SYNC;
        else
            return PH_BACK;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle between the timing generator (master) and the pixel
// pipeline / framebuffer reader (slave). The slave supplies the pixel enable.
interface vga_timing_gen_if #(
    parameter int CNT_W = 10
);
    logic             pix_en;
    logic             hsync;
    logic             vsync;
    logic             video_on;
    logic [CNT_W-1:0] h_count;
    logic [CNT_W-1:0] v_count;
    logic             line_start;
    logic             frame_start;

    modport master (
        input  pix_en,
        output hsync, vsync, video_on, h_count, v_count, line_start, frame_start
    );

    modport slave (
        output pix_en,
        input  hsync, vsync, video_on, h_count, v_count, line_start, frame_start
    );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position register plus the next-state position and the
// phase decodes of that next position, so the parent can register them in step.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int VISIBLE = 640,
    parameter int FRONT   = 16,
    parameter int SYNC    = 96,
    parameter int BACK    = 48,
    parameter int CNT_W   = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    output logic [CNT_W-1:0] next_count,
    output logic             wrap,
    output logic             next_in_sync,
    output logic             next_in_visible
);
    localparam int TOTAL = axis_total(VISIBLE, FRONT, SYNC, BACK);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

    logic [CNT_W-1:0] count;
    phase_e           next_phase;

    assign wrap = (count == LAST);

    always_comb begin
        next_count = count;
        if (step)
            next_count = wrap ? '0 : count + CNT_W'(1);
    end

    assign next_phase      = phase_of(int'(next_count), VISIBLE, FRONT, SYNC);
    assign next_in_sync    = (next_phase == PH_SYNC);
    assign next_in_visible = (next_phase == PH_ACTIVE);

    // Parking on the last back-porch position makes the first step land on 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= LAST;
        else
            count <= next_count;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: chains the horizontal wrap into the
// vertical step and registers counts, polarised syncs, video flag and strobes.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    vga_timing_gen_if.master         vid
);
    localparam int H_TOTAL = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    if (H_VISIBLE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
        V_VISIBLE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_timing
        $error("vga_timing_gen: every timing parameter must be at least 1");
    end
    if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_width
        $error("vga_timing_gen: CNT_W too narrow for the line or frame total");
    end

    logic             h_step, v_step;
    logic             h_wrap, v_wrap;
    logic [CNT_W-1:0] h_next, v_next;
    logic             h_in_sync, v_in_sync;
    logic             h_in_vis, v_in_vis;

    assign h_step = vid.pix_en;
    assign v_step = vid.pix_en && h_wrap;

    vga_axis_counter #(
        .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .CNT_W(CNT_W)
    ) u_h_axis (
        .clk             (clk),
        .reset           (reset),
        .step            (h_step),
        .next_count      (h_next),
        .wrap            (h_wrap),
        .next_in_sync    (h_in_sync),
        .next_in_visible (h_in_vis)
    );

    vga_axis_counter #(
        .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .CNT_W(CNT_W)
    ) u_v_axis (
        .clk             (clk),
        .reset           (reset),
        .step            (v_step),
        .next_count      (v_next),
        .wrap            (v_wrap),
        .next_in_sync    (v_in_sync),
        .next_in_visible (v_in_vis)
    );

    logic [CNT_W-1:0] h_count_q, v_count_q;
    logic             hsync_q, vsync_q, video_on_q, line_start_q, frame_start_q;

    // Decodes come from the next-state counts so every output lines up with
    // the counts registered on the same edge; holding pix_en low holds them too.
    // NOTE: non-blocking assignments here so all outputs sample pre-edge values together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_count_q     <= CNT_W'(H_TOTAL - 1);
            v_count_q     <= CNT_W'(V_TOTAL - 1);
            hsync_q       <= !HSYNC_POL;
            vsync_q       <= !VSYNC_POL;
            video_on_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_count_q     <= h_next;
            v_count_q     <= v_next;
            hsync_q       <= h_in_sync ? HSYNC_POL : !HSYNC_POL;
            vsync_q       <= v_in_sync ? VSYNC_POL : !VSYNC_POL;
            video_on_q    <= h_in_vis && v_in_vis;
            line_start_q  <= vid.pix_en && h_wrap;
            frame_start_q <= vid.pix_en && h_wrap && v_wrap;
        end
    end

    assign vid.h_count     = h_count_q;
    assign vid.v_count     = v_count_q;
    assign vid.hsync       = hsync_q;
    assign vid.vsync       = vsync_q;
    assign vid.video_on    = video_on_q;
    assign vid.line_start  = line_start_q;
    assign vid.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a default 640x480 instance and a tiny positive-polarity
// instance, both compared every cycle against a linear-position raster model.
module tb_vga_timing_gen;

    typedef struct {
        int hv, hf, hs, hb;
        int vv, vf, vs, vb;
        bit hpol, vpol;
    } tim_t;

    typedef struct packed {
        logic [15:0] h;
        logic [15:0] v;
        logic        hs;
        logic        vs;
        logic        von;
        logic        ls;
        logic        fs;
    } obs_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vga_timing_gen_if #(.CNT_W(10)) bus_a ();
    vga_timing_gen_if #(.CNT_W(4))  bus_b ();

    vga_timing_gen dut_a (
        .clk   (clk),
        .reset (reset),
        .vid   (bus_a)
    );

    vga_timing_gen #(
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CNT_W(4)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .vid   (bus_b)
    );

    tim_t ta, tb;
    int   pa, pb;           // linear position within the frame, 0..H_TOTAL*V_TOTAL-1
    bit   sa, sb;           // an enabled step happened on the last edge
    obs_t qa[$];
    obs_t qb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic int line_len(input tim_t t);
        return t.hv + t.hf + t.hs + t.hb;
    endfunction

    function automatic int frame_len(input tim_t t);
        return line_len(t) * (t.vv + t.vf + t.vs + t.vb);
    endfunction

    function automatic obs_t model_out(input tim_t t, input int p, input bit stepped);
        obs_t o;
        int   h, v;
        h = p % line_len(t);
        v = p / line_len(t);
        o.h   = 16'(h);
        o.v   = 16'(v);
        o.hs  = (h >= t.hv + t.hf && h < t.hv + t.hf + t.hs) ? t.hpol : !t.hpol;
        o.vs  = (v >= t.vv + t.vf && v < t.vv + t.vf + t.vs) ? t.vpol : !t.vpol;
        o.von = (h < t.hv) && (v < t.vv);
        o.ls  = stepped && (h == 0);
        o.fs  = stepped && (p == 0);
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("h=%0d v=%0d hs=%b vs=%b von=%b ls=%b fs=%b",
                         o.h, o.v, o.hs, o.vs, o.von, o.ls, o.fs);
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got {%s} want {%s}", name, $time, fmt(act), fmt(exp));
        end
    endtask

    // One clock: advance the model by the inputs that were present at the edge,
    // apply new inputs (reset acts at once), then queue the expected outputs.
    task automatic tick(input bit ea, input bit eb, input bit r);
        @(posedge clk);
        #1;
        if (reset) begin
            pa = frame_len(ta) - 1; sa = 1'b0;
            pb = frame_len(tb) - 1; sb = 1'b0;
        end else begin
            sa = bus_a.pix_en;
            sb = bus_b.pix_en;
            if (sa) pa = (pa + 1) % frame_len(ta);
            if (sb) pb = (pb + 1) % frame_len(tb);
        end
        reset        = r;
        bus_a.pix_en = ea;
        bus_b.pix_en = eb;
        if (r) begin
            pa = frame_len(ta) - 1; sa = 1'b0;
            pb = frame_len(tb) - 1; sb = 1'b0;
        end
        qa.push_back(model_out(ta, pa, sa));
        qb.push_back(model_out(tb, pb, sb));
    endtask

    // Monitor: every output is valid each cycle; sample at the falling edge.
    initial begin
        obs_t act;
        forever begin
            @(negedge clk);
            if (qa.size() > 0) begin
                act = '{h: 16'(bus_a.h_count), v: 16'(bus_a.v_count), hs: bus_a.hsync,
                        vs: bus_a.vsync, von: bus_a.video_on, ls: bus_a.line_start,
                        fs: bus_a.frame_start};
                check("dut_a", act, qa.pop_front());
            end
            if (qb.size() > 0) begin
                act = '{h: 16'(bus_b.h_count), v: 16'(bus_b.v_count), hs: bus_b.hsync,
                        vs: bus_b.vsync, von: bus_b.video_on, ls: bus_b.line_start,
                        fs: bus_b.frame_start};
                check("dut_b", act, qb.pop_front());
            end
        end
    end

    initial begin
        ta = '{hv: 640, hf: 16, hs: 96, hb: 48, vv: 480, vf: 10, vs: 2, vb: 33,
               hpol: 1'b0, vpol: 1'b0};
        tb = '{hv: 4, hf: 1, hs: 2, hb: 1, vv: 3, vf: 1, vs: 1, vb: 1,
               hpol: 1'b1, vpol: 1'b1};
        reset        = 1'b1;
        bus_a.pix_en = 1'b0;
        bus_b.pix_en = 1'b0;
        pa = frame_len(ta) - 1; sa = 1'b0;
        pb = frame_len(tb) - 1; sb = 1'b0;

        repeat (3) tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);

        // Continuous enable on the default raster; 1,0 toggling on the small one.
        for (int i = 0; i < 2500; i++)
            tick(1'b1, (i % 2) == 0, 1'b0);

        for (int i = 0; i < 3000; i++)
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 1'b0);

        // Mid-frame asynchronous reset held for three clocks.
        repeat (3) tick(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 1200; i++)
            tick(1'b1, 1'b1, 1'b0);

        for (int i = 0; i < 500; i++)
            tick($urandom_range(0, 1) == 1, $urandom_range(0, 4) != 0, 1'b0);

        @(negedge clk);
        #1;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d/%0d expected entries never compared, want 0",
                     qa.size(), qb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA/raster timing generator: the next generation of the fixed 640x480 sync block. It produces horizontal and vertical counters, sync pulses with configurable polarity, an active-video flag, and line/frame start strobes, all registered and mutually aligned. It sits between the pixel-clock domain and the pixel pipeline and framebuffer reader. A clock enable allows a fast system clock to drive a slower pixel rate.

## Interface
Parameters:
- H_VISIBLE, 640: active pixels per line
- H_FRONT, 16: horizontal front porch, in pixels
- H_SYNC, 96: horizontal sync width, in pixels
- H_BACK, 48: horizontal back porch, in pixels
- V_VISIBLE, 480: active lines per frame
- V_FRONT, 10: vertical front porch, in lines
- V_SYNC, 2: vertical sync width, in lines
- V_BACK, 33: vertical back porch, in lines
- HSYNC_POL, 0: active level of hsync (0 = active-low)
- VSYNC_POL, 0: active level of vsync (0 = active-low)
- CNT_W, 10: counter width; H_TOTAL and V_TOTAL must be ≤ 2^CNT_W

Ports:
- clk  in  1  system/pixel clock
- reset  in  1  asynchronous, active-high
- pix_en  in  1  pixel clock enable; counters advance only when high
- hsync  out  1  horizontal sync, driven at HSYNC_POL when active
- vsync  out  1  vertical sync, driven at VSYNC_POL when active
- video_on  out  1  high when h_count < H_VISIBLE and v_count < V_VISIBLE
- h_count  out  CNT_W  pixel position, 0..H_TOTAL-1
- v_count  out  CNT_W  line position, 0..V_TOTAL-1
- line_start  out  1  one-clk pulse when h_count becomes 0
- frame_start  out  1  one-clk pulse when h_count and v_count both become 0

## Operation
- H_TOTAL = sum of the four H parameters; V_TOTAL = sum of the four V parameters. Every parameter must be ≥ 1; elaboration fails otherwise.
- Each axis runs a phase sequence ACTIVE → FRONT → SYNC → BACK → ACTIVE, which is tracked by the counter value.
- Horizontal counter, on a cycle with pix_en=1: increments, and wraps from H_TOTAL-1 to 0.
- Vertical counter: increments only on a cycle with pix_en=1 and h_count=H_TOTAL-1, and wraps from V_TOTAL-1 to 0.
- hsync is active for H_VISIBLE+H_FRONT ≤ h_count < H_VISIBLE+H_FRONT+H_SYNC.
- vsync is active for the matching v_count range.
- hsync and vsync switch in the same cycle as the counts change; a vsync edge coincides with the h wrap.
- All outputs are registered. hsync, vsync and video_on are decoded from the next-state counter values, so they always match the h_count and v_count values presented in the same cycle.
- With pix_en=0, all outputs hold, except line_start and frame_start, which drop to 0.
- Reset state:
  - h_count = H_TOTAL-1, v_count = V_TOTAL-1 (last back-porch pixel).
  - hsync = !HSYNC_POL, vsync = !VSYNC_POL.
  - video_on = 0, line_start = 0, frame_start = 0.
  - Because of this state, the first pix_en after reset produces (0,0) with line_start=1 and frame_start=1, and no pixel of frame 0 is lost.
- Reset asserted mid-frame returns outputs to the reset state immediately and asynchronously; there is no partial-frame continuation.

## Timing
- Latency: pix_en sampled high at edge N gives new counts and decodes valid after edge N. This is one register stage, with no extra pipeline.
- line_start is high for exactly one clk following the edge that loads h_count=0, regardless of pix_en in the next cycle.
- frame_start is high for exactly one clk following the edge that loads (0,0). It always coincides with a line_start.
- Frame period = H_TOTAL·V_TOTAL pix_en pulses; with the default parameters that is 420000.
- Simultaneous h wrap and v wrap happen in one edge; there is no one-cycle skew between the axes.
- pix_en may have any duty pattern. Consecutive enables need no minimum spacing.

## Structure
- Shared package vga_pkg holds:
  - Default 640x480@60 timing localparams.
  - A phase enum (PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK).
  - A helper function returning total = visible+front+sync+back.
- One sub-module, vga_axis_counter, is instantiated twice (horizontal and vertical):
  - Parameters: VISIBLE/FRONT/SYNC/BACK/CNT_W.
  - Inputs: step.
  - Outputs: next count, wrap flag, next-in-sync and next-in-visible.
  - It is combinational next-state logic plus the count register.
- The top level chains h wrap into v step, owns the output registers, applies the polarity, and generates the strobes.

## Test plan
- Reset with defaults → h=799, v=524, hsync=1, vsync=1, video_on=0, strobes 0. First pix_en → h=0, v=0, video_on=1, line_start=1, frame_start=1.
- pix_en held high, defaults → hsync low exactly for h 656..751. vsync low exactly for v 490..491. video_on high for 307200 cycles per frame. frame_start every 420000 cycles.
- pix_en toggling 1,0 → frame_start every 840000 clks. Counts and syncs stable on pix_en=0 cycles. Strobes are only one clk wide.
- HSYNC_POL=1, VSYNC_POL=1 → hsync high only for h 656..751, vsync high only for v 490..491, and low after reset.
- Small timing (H 4/1/2/1, V 3/1/1/1, CNT_W 4) → frame of 8×6=48 enables. Check every (h,v,hsync,vsync,video_on) value against a reference model.
- Assert reset at h=300, v=200 for 3 clks → outputs immediately return to the reset state. First pix_en after release gives frame_start=1 at (0,0).
